// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// master = producer/consumer side, slave = the adder/subtractor pipeline.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined add/subtract built from ripple-chained 4-bit CLA slices, valid/ready on both sides.
// Optional macro CLA_ADDSUB_SAT_EN clamps the sum to the signed limits on overflow.
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_addsub_pipe_if.slave     bus
);
    localparam int H = WIDTH / 2;

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // One half-width adder: slices ripple their group carry into the next slice.
    function automatic logic [H:0] cla_chain(input logic [H-1:0] x, input logic [H-1:0] y, input logic c0);
        logic [H-1:0] s;
        logic         c;
        logic [4:0]   r;
        s = '0;
        c = c0;
        for (int i = 0; i < H / 4; i++) begin
            r          = cla4(x[4*i +: 4], y[4*i +: 4], c);
            s[4*i +: 4] = r[3:0];
            c          = r[4];
        end
        return {c, s};
    endfunction

    logic             s1_valid;
    logic [H-1:0]     s1_sum_lo;
    logic             s1_c;
    logic [H-1:0]     s1_a_hi;
    logic [H-1:0]     s1_b_hi;

    logic [WIDTH-1:0] bx;
    logic             cx;
    logic [H:0]       lo;
    logic [H:0]       hi;
    logic [WIDTH-1:0] sum_n;
    logic             ovf_n;
    logic             s2_adv;
    logic             accept;

    assign bx     = bus.sub ? ~bus.b : bus.b;
    assign cx     = bus.sub ? ~bus.cin : bus.cin;
    assign lo     = cla_chain(bus.a[H-1:0], bx[H-1:0], cx);
    assign hi     = cla_chain(s1_a_hi, s1_b_hi, s1_c);

    assign s2_adv       = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        ovf_n = (s1_a_hi[H-1] == s1_b_hi[H-1]) && (hi[H-1] != s1_a_hi[H-1]);
        sum_n = {hi[H-1:0], s1_sum_lo};
`ifdef CLA_ADDSUB_SAT_EN
        // Clamp direction follows the sign of A: both operands share it when overflow occurs.
        if (ovf_n)
            sum_n = s1_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sum_lo     <= '0;
            s1_c          <= 1'b0;
            s1_a_hi       <= '0;
            s1_b_hi       <= '0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_sum_lo <= lo[H-1:0];
                s1_c      <= lo[H];
                s1_a_hi   <= bus.a[WIDTH-1:H];
                s1_b_hi   <= bx[WIDTH-1:H];
            end else if (s2_adv) begin
                s1_valid  <= 1'b0;
            end

            if (s2_adv) begin
                bus.out_valid <= 1'b1;
                bus.sum       <= sum_n;
                bus.cout      <= hi[H];
                bus.ovf       <= ovf_n;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed corner cases, randomized stream with
// random back-pressure against an arithmetic reference model, and mid-flight reset.
module tb_cla_addsub_pipe;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(W)) bus();
    cla_addsub_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   step   = 0;
    int   nres   = 0;
    logic last_acc = 1'b0;
    logic use_const = 1'b0;
    exp_t cexp;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W:0]   t;
        logic [W-1:0] bv;
        logic         cv;
        bv = sub ? ~b : b;
        cv = sub ? ~cin : cin;
        t  = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.cout = t[W];
        e.ovf  = (a[W-1] == bv[W-1]) && (t[W-1] != a[W-1]);
        e.sum  = t[W-1:0];
`ifdef CLA_ADDSUB_SAT_EN
        if (e.ovf) e.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called just after a falling edge with inputs set; samples, checks, then advances one clock.
    task automatic cycle();
        exp_t e;
        logic exp_ov;
        #1;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (step >= q[0].acc + 2);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
            chk("result_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sum", 32'(bus.sum), 32'(e.sum));
                chk("cout", 32'(bus.cout), 32'(e.cout));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                nres++;
            end
        end
        last_acc = bus.in_valid && bus.in_ready;
        if (last_acc) begin
            e = use_const ? cexp : model(bus.a, bus.b, bus.cin, bus.sub);
            e.acc = step;
            q.push_back(e);
        end
        @(posedge clk);
        step++;
        @(negedge clk);
    endtask

    task automatic run_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        use_const = 1'b1;
        cexp.sum = es; cexp.cout = ec; cexp.ovf = eo; cexp.acc = 0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!last_acc && n < 10);
        bus.in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 10) begin cycle(); n++; end
        chk({"drain_", tag}, 32'(q.size()), 32'd0);
        use_const = 1'b0;
    endtask

    task automatic new_ops();
        bus.a   = W'($urandom_range(0, 65535));
        bus.b   = W'($urandom_range(0, 65535));
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_dir("add5_6", 16'h0005, 16'h0006, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0);
        run_dir("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir("sub3_5", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef CLA_ADDSUB_SAT_EN
        run_dir("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_dir("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        run_dir("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_dir("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Randomized stream with pseudo-random consumer back-pressure.
        nres = 0;
        sent = 0;
        new_ops();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300 && (sent < 8 || q.size() > 0); i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) begin
                sent++;
                if (sent < 8) new_ops();
                else bus.in_valid = 1'b0;
            end
        end
        chk("stream_count", 32'(nres), 32'd8);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // Fill both stages under stall, then reset mid-flight.
        bus.out_ready = 1'b0;
        new_ops(); bus.in_valid = 1'b1;
        cycle();
        new_ops();
        cycle();
        new_ops();
        cycle();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();

        run_dir("post_rst", 16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0234, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
